// File: rtl/nmi_arbiter.sv
// Single-owner NMI arbiter for three requesters (magic, divmmc, debug).
// NMI assertion is aligned to the frame strobe and held until the 0x0066 fetch or a frame timeout.
module nmi_arbiter #(
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        n_int,
  input  logic        n_int_next,
  input  logic [2:0]  req,
  input  logic [2:0]  done,
  input  logic        nmi_enable,
  input  logic        bus_m1,
  input  logic        bus_memreq,
  input  logic [15:0] bus_a_reg,
  output logic        n_nmi,
  output logic [2:0]  grant,
  output logic        active,
  output logic        timeout
);

  localparam int CW = (TIMEOUT_FRAMES < 1) ? 1 : $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW:0]   TO_VAL  = TIMEOUT_FRAMES[CW:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_ASSERT,
    S_SERVICE
  } state_t;

  state_t        r_state, r_state_next;
  logic          r_n_nmi, r_n_nmi_next;
  logic [2:0]    r_grant, r_grant_next;
  logic          r_active, r_active_next;
  logic          r_timeout, r_timeout_next;
  logic [1:0]    r_id, r_id_next;
  logic [CW-1:0] r_cnt, r_cnt_next;
  logic [2:0]    r_pending, r_pending_next;
  logic [2:0]    r_req_prev;

  logic          w_frame;
  logic          w_ack;
  logic [2:0]    w_rise;
  logic [2:0]    w_clear;
  logic [2:0]    w_id_onehot;
  logic [CW:0]   w_cnt_inc;

  assign w_frame     = n_int && !n_int_next;
  assign w_ack       = bus_m1 && bus_memreq && (bus_a_reg == 16'h0066);
  assign w_rise      = req & ~r_req_prev & {3{nmi_enable}};
  assign w_id_onehot = 3'b001 << r_id;
  assign w_cnt_inc   = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};

  // A fresh edge on the granted bit wins over its clear, so a re-request is never lost.
  assign r_pending_next = (r_pending & ~w_clear) | w_rise;

  always_comb begin
    r_state_next   = r_state;
    r_n_nmi_next   = r_n_nmi;
    r_grant_next   = r_grant;
    r_timeout_next = 1'b0;
    r_id_next      = r_id;
    r_cnt_next     = r_cnt;
    w_clear        = 3'b000;

    case (r_state)
      S_IDLE: begin
        if (r_pending != 3'b000) begin
          if (r_pending[0])      r_id_next = 2'd0;
          else if (r_pending[1]) r_id_next = 2'd1;
          else                   r_id_next = 2'd2;
          r_state_next = S_WAIT_FRAME;
        end
      end
      S_WAIT_FRAME: begin
        if (w_frame) begin
          r_n_nmi_next = 1'b0;
          r_grant_next = w_id_onehot;
          w_clear      = w_id_onehot;
          r_cnt_next   = '0;
          r_state_next = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (w_ack) begin
          r_n_nmi_next = 1'b1;
          r_state_next = S_SERVICE;
        end else if (w_frame) begin
          if (r_cnt != CNT_MAX) r_cnt_next = w_cnt_inc[CW-1:0];
          if (TIMEOUT_FRAMES != 0 && w_cnt_inc == TO_VAL) begin
            r_n_nmi_next   = 1'b1;
            r_grant_next   = 3'b000;
            r_timeout_next = 1'b1;
            r_state_next   = S_IDLE;
          end
        end
      end
      S_SERVICE: begin
        // In SERVICE the grant is the owner's one-hot, so this ignores non-owner done bits.
        if ((done & r_grant) != 3'b000) begin
          r_grant_next = 3'b000;
          r_state_next = S_IDLE;
        end
      end
      default: r_state_next = S_IDLE;
    endcase

    r_active_next = (r_state_next != S_IDLE);
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_n_nmi    <= 1'b1;
      r_grant    <= 3'b000;
      r_active   <= 1'b0;
      r_timeout  <= 1'b0;
      r_id       <= 2'd0;
      r_cnt      <= '0;
      r_pending  <= 3'b000;
      r_req_prev <= 3'b111;
    end else begin
      r_state    <= r_state_next;
      r_n_nmi    <= r_n_nmi_next;
      r_grant    <= r_grant_next;
      r_active   <= r_active_next;
      r_timeout  <= r_timeout_next;
      r_id       <= r_id_next;
      r_cnt      <= r_cnt_next;
      r_pending  <= r_pending_next;
      r_req_prev <= req;
    end
  end

  assign n_nmi   = r_n_nmi;
  assign grant   = r_grant;
  assign active  = r_active;
  assign timeout = r_timeout;

endmodule
